draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Shares the single VGA adapter plot port (160x120, 9-bit colour) between several drawing requesters: meat pieces, the score stacks and background clears.
- Each requester asks for a solid-colour rectangle fill.
- The block arbitrates round-robin, latches the winner's rectangle and scans it one pixel per clock onto x_draw/y_draw/colour/plot.
- It then pulses done to the winner.

Parameters:
- N_REQ, 4, number of requesters.
- DIM_W, 6, width of rectangle width/height fields (max 63 px).
- SCREEN_W, 160, horizontal pixel limit (exclusive).
- SCREEN_H, 120, vertical pixel limit (exclusive).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester draw request; level, held until done.
- req_x  in  N_REQ*8  rectangle left x, requester i at bits [8i+7:8i].
- req_y  in  N_REQ*8  rectangle top y.
- req_w  in  N_REQ*DIM_W  rectangle width in pixels.
- req_h  in  N_REQ*DIM_W  rectangle height in pixels.
- req_colour  in  N_REQ*9  fill colour (3 bits per channel).
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- done  out  N_REQ  one-cycle pulse to the owner when its rectangle completes.
- x_draw  out  8  pixel x to VGA adapter.
- y_draw  out  8  pixel y to VGA adapter.
- colour  out  9  pixel colour to VGA adapter.
- plot  out  1  write enable to VGA adapter.
- busy  out  1  high in DRAW or DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0 (req[0] highest priority).
- States: IDLE, DRAW, DONE.
- IDLE, req != 0 on an edge:
  - Pick winner g as the first set req bit at or after the pointer, wrapping.
  - Set grant <= onehot(g).
  - Latch x0, y0, w, h, col from slot g.
  - Clear counters cx = cy = 0.
  - Next state DRAW, or DONE if w == 0 or h == 0.
- req and rectangle fields are sampled only at grant. Later changes, including req dropping mid-draw, are ignored and the draw completes.
- DRAW:
  - Outputs are combinational from registered state: x_draw = (x0+cx)[7:0], y_draw = (y0+cy)[7:0], colour = col.
  - plot = 1 iff the 9-bit sums satisfy x0+cx < SCREEN_W and y0+cy < SCREEN_H. Off-screen pixels still consume a cycle with plot = 0.
  - Raster order, x inner: cx increments each cycle. At cx == w-1, cx resets to 0 and cy increments.
  - At cx == w-1 and cy == h-1, next state DONE.
  - Exactly w*h DRAW cycles. The first pixel appears on the cycle after the req is sampled.
- DONE, one cycle:
  - done[g] = 1, plot = 0, x_draw/y_draw/colour = 0.
  - On the edge: grant <= 0, pointer <= (g+1) mod N_REQ, next state IDLE.
- No back-to-back grants: at least one IDLE cycle between owners.
- Outside DRAW: plot = 0, x_draw = y_draw = colour = 0.
- Reset mid-operation:
  - Next cycle: state IDLE, grant = 0, plot = 0, no done pulse, pointer = 0.
  - The interrupted requester, if still requesting, restarts from pixel (0,0).
- Simultaneous events: requests arriving during DRAW/DONE wait. An owner's req staying high after done is treated as a new request and competes under the rotated pointer.
- Counters are DIM_W wide. Coordinate sums are 9 bits wide, so there is no wrap onto the visible screen.

Decomposition:
- Shared package/header (alongside definition.vh):
  - SCREEN_W and SCREEN_H.
  - COLOUR_W = 9.
  - State encodings: IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2.
  - Named colour constants (fat, muscle, black).
- One sub-module, rr_arbiter:
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant and binary index.
  - Purely combinational selection; the pointer register lives in draw_scheduler.

Test Plan:
- Basic fill, after reset, req[0]=1 with x=10, y=20, w=3, h=2, colour=9'h1C0:
  - grant=4'b0001 from cycle 1.
  - plot=1 cycles 1-6 at (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), colour 9'h1C0.
  - done[0]=1 at cycle 7; grant=0 at cycle 8.
- Round-robin, req[0] and req[1] held high continuously, each with w=h=1:
  - Grant sequence 0,1,0,1.
  - Each ownership is 1 DRAW + 1 DONE cycle, separated by one IDLE cycle.
- Clipping, x=158, y=119, w=4, h=2:
  - 8 DRAW cycles.
  - plot=1 only for (158,119) and (159,119); the other 6 cycles have plot=0.
  - done pulses after cycle 8.
- Empty rectangle, w=0, h=5:
  - No plot ever.
  - grant at cycle 1, done pulse at cycle 1 (DONE state).
  - Back to IDLE at cycle 2.
- Reset mid-draw, w=4, h=4 request; reset asserted in DRAW cycle 5 for one cycle:
  - Next cycle plot=0, grant=0, done never pulses.
  - After release, with req still high, the draw restarts at (x0,y0) and completes all 16 pixels.
- Request change mid-draw: altering req_x and dropping req[0] during DRAW has no effect on the pixel stream; done[0] still pulses.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared screen limits, colour width, scheduler state encodings and palette
// used by the draw scheduler slice.
package draw_scheduler_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 3 bits per channel, RRRGGGBBB
    localparam logic [COLOUR_W-1:0] COL_FAT    = 9'h1B6;
    localparam logic [COLOUR_W-1:0] COL_MUSCLE = 9'h180;
    localparam logic [COLOUR_W-1:0] COL_BLACK  = 9'h000;
endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after pointer,
// wrapping. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx
);
    int  j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(pointer) + k) % N_REQ;
            if (enable && !found && req[j]) begin
                found  = 1'b1;
                idx    = PTR_W'(j);
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA plot port between requesters: round-robin grant, then a
// raster scan of the winner's solid rectangle, one pixel per clock.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DIM_W    = 6,
    parameter int SCREEN_W = draw_scheduler_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_scheduler_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*8-1:0]        req_x,
    input  logic [N_REQ*8-1:0]        req_y,
    input  logic [N_REQ*DIM_W-1:0]    req_w,
    input  logic [N_REQ*DIM_W-1:0]    req_h,
    input  logic [N_REQ*COLOUR_W-1:0] req_colour,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [7:0]                x_draw,
    output logic [7:0]                y_draw,
    output logic [COLOUR_W-1:0]       colour,
    output logic                      plot,
    output logic                      busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]          state;
    logic [PTR_W-1:0]    ptr, owner, arb_idx;
    logic [N_REQ-1:0]    arb_gnt;
    logic [7:0]          x0, y0;
    logic [DIM_W-1:0]    w, h, cx, cy;
    logic [COLOUR_W-1:0] col;
    logic [DIM_W-1:0]    nw, nh;
    logic [8:0]          xs, ys;
    logic                in_draw;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req     (req),
        .pointer (ptr),
        .enable  (state == ST_IDLE),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    assign nw = req_w[arb_idx*DIM_W +: DIM_W];
    assign nh = req_h[arb_idx*DIM_W +: DIM_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            col   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|arb_gnt) begin
                    grant <= arb_gnt;
                    owner <= arb_idx;
                    x0    <= req_x[arb_idx*8 +: 8];
                    y0    <= req_y[arb_idx*8 +: 8];
                    w     <= nw;
                    h     <= nh;
                    col   <= req_colour[arb_idx*COLOUR_W +: COLOUR_W];
                    cx    <= '0;
                    cy    <= '0;
                    state <= (nw == '0 || nh == '0) ? ST_DONE : ST_DRAW;
                end
                ST_DRAW: begin
                    if (cx == w - DIM_W'(1)) begin
                        cx <= '0;
                        if (cy == h - DIM_W'(1)) state <= ST_DONE;
                        else                     cy    <= cy + DIM_W'(1);
                    end else begin
                        cx <= cx + DIM_W'(1);
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    ptr   <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // 9-bit sums so an off-screen pixel never aliases back onto the screen
    assign xs      = {1'b0, x0} + 9'(cx);
    assign ys      = {1'b0, y0} + 9'(cy);
    assign in_draw = (state == ST_DRAW);

    assign plot   = in_draw && (xs < 9'(SCREEN_W)) && (ys < 9'(SCREEN_H));
    assign x_draw = in_draw ? xs[7:0] : '0;
    assign y_draw = in_draw ? ys[7:0] : '0;
    assign colour = in_draw ? col : '0;
    assign done   = (state == ST_DONE) ? grant : '0;
    assign busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: fill, round-robin, clipping, empty rect,
// reset mid-draw and request changes mid-draw.
module tb_draw_scheduler;
    localparam int N_REQ = 4;
    localparam int DIM_W = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*8-1:0]     req_x, req_y;
    logic [N_REQ*DIM_W-1:0] req_w, req_h;
    logic [N_REQ*9-1:0]     req_colour;
    logic [N_REQ-1:0]       grant, done;
    logic [7:0]             x_draw, y_draw;
    logic [8:0]             colour;
    logic                   plot, busy;

    int total = 0;
    int bad   = 0;

    draw_scheduler #(.N_REQ(N_REQ), .DIM_W(DIM_W)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_colour(req_colour), .grant(grant), .done(done),
        .x_draw(x_draw), .y_draw(y_draw), .colour(colour),
        .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [7:0] x, input logic [7:0] y,
                            input logic [5:0] w, input logic [5:0] h, input logic [8:0] c);
        req_x[i*8 +: 8]       = x;
        req_y[i*8 +: 8]       = y;
        req_w[i*DIM_W +: DIM_W] = w;
        req_h[i*DIM_W +: DIM_W] = h;
        req_colour[i*9 +: 9]  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Pixel table for the basic 3x2 fill at (10,20)
    logic [7:0] fx [6] = '{10, 11, 12, 10, 11, 12};
    logic [7:0] fy [6] = '{20, 20, 20, 21, 21, 21};
    // Clipping 4x2 at (158,119): only first two pixels are on screen
    logic       cp [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [7:0] cxv[8] = '{158, 159, 160, 161, 158, 159, 160, 161};
    logic [7:0] cyv[8] = '{119, 119, 119, 119, 120, 120, 120, 120};
    // Mid-draw change 2x2 at (30,40)
    logic [7:0] mx [4] = '{30, 31, 30, 31};
    logic [7:0] my [4] = '{40, 40, 41, 41};

    initial begin
        req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xy", {x_draw, y_draw, colour}, 0);

        // basic fill
        set_slot(0, 10, 20, 3, 2, 9'h1C0);
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fill_grant", grant, 4'b0001);
            chk("fill_plot", plot, 1);
            chk("fill_x", x_draw, fx[k]);
            chk("fill_y", y_draw, fy[k]);
            chk("fill_col", colour, 9'h1C0);
            chk("fill_done", done, 0);
        end
        step();
        chk("fill_done7", done, 4'b0001);
        chk("fill_plot7", plot, 0);
        chk("fill_x7", x_draw, 0);
        req = '0;
        step();
        chk("fill_grant8", grant, 0);
        chk("fill_busy8", busy, 0);

        // round-robin from a fresh pointer
        do_reset();
        set_slot(0, 1, 2, 1, 1, 9'h007);
        set_slot(1, 50, 60, 1, 1, 9'h038);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant", grant, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            chk("rr_plot", plot, 1);
            chk("rr_x", x_draw, (k % 2 == 0) ? 8'd1 : 8'd50);
            step();
            chk("rr_done", done, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            step();
            chk("rr_idle_grant", grant, 0);
            chk("rr_idle_busy", busy, 0);
            if (k == 3) req = '0;
        end

        // clipping: pointer now 2, use slot 2
        set_slot(2, 158, 119, 4, 2, 9'h1FF);
        req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("clip_grant", grant, 4'b0100);
            chk("clip_busy", busy, 1);
            chk("clip_plot", plot, cp[k]);
            chk("clip_x", x_draw, cxv[k]);
            chk("clip_y", y_draw, cyv[k]);
            chk("clip_done", done, 0);
        end
        step();
        chk("clip_done9", done, 4'b0100);
        req = '0;
        step();
        chk("clip_idle", busy, 0);

        // empty rectangle on slot 3
        set_slot(3, 5, 5, 0, 5, 9'h0AA);
        req = 4'b1000;
        step();
        chk("empty_grant", grant, 4'b1000);
        chk("empty_done", done, 4'b1000);
        chk("empty_plot", plot, 0);
        req = '0;
        step();
        chk("empty_idle_grant", grant, 0);
        chk("empty_idle_busy", busy, 0);
        chk("empty_idle_plot", plot, 0);

        // reset mid-draw, 4x4 at (5,7)
        set_slot(0, 5, 7, 4, 4, 9'h111);
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rmd_pre_done", done, 0);
        end
        chk("rmd_c5_x", x_draw, 5);
        chk("rmd_c5_y", y_draw, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmd_grant", grant, 0);
        chk("rmd_plot", plot, 0);
        chk("rmd_done", done, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("rmd_plot_r", plot, 1);
            chk("rmd_x", x_draw, 8'(5 + k % 4));
            chk("rmd_y", y_draw, 8'(7 + k / 4));
            chk("rmd_done_r", done, 0);
        end
        step();
        chk("rmd_done_end", done, 4'b0001);
        req = '0;
        step();
        chk("rmd_idle", busy, 0);

        // request fields change mid-draw
        set_slot(0, 30, 40, 2, 2, 9'h0F0);
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                req_x[7:0] = 8'd99;
                req = '0;
            end
            chk("chg_plot", plot, 1);
            chk("chg_x", x_draw, mx[k]);
            chk("chg_y", y_draw, my[k]);
            chk("chg_col", colour, 9'h0F0);
        end
        step();
        chk("chg_done", done, 4'b0001);
        step();
        chk("chg_idle", grant, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
